// File: rtl/alarm_timer_ctrl.sv
// Countdown timer for the anti-theft FSM: four run-time programmable
// second-granularity delays, a free-running 1 Hz strobe and an expiry pulse.
module alarm_timer_ctrl #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int T_ARM_DEF       = 6,
    parameter int T_DRIVER_DEF    = 8,
    parameter int T_PASSENGER_DEF = 15,
    parameter int T_ALARM_DEF     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       one_hz_enable,
    output logic [3:0] time_left,
    output logic       running
);

    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] TC = PW'(CLK_FREQ_HZ - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_d;
    logic [PW-1:0] div_cnt;
    logic [PW-1:0] tpre, tpre_d;
    logic [3:0]    params [4];
    logic          start_q;
    logic [1:0]    interval_q;
    logic [3:0]    time_left_d;
    logic          expired_d;
    logic          running_d;
    logic          load;

    // Free-running seconds divider, independent of the timer state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt       <= '0;
            one_hz_enable <= 1'b0;
        end else if (div_cnt == TC) begin
            div_cnt       <= '0;
            one_hz_enable <= 1'b1;
        end else begin
            div_cnt       <= div_cnt + PW'(1);
            one_hz_enable <= 1'b0;
        end
    end

    // Parameter store, rewritten by the reprogram pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            params[0] <= 4'(T_ARM_DEF);
            params[1] <= 4'(T_DRIVER_DEF);
            params[2] <= 4'(T_PASSENGER_DEF);
            params[3] <= 4'(T_ALARM_DEF);
        end else if (reprogram) begin
            params[param_sel] <= time_value;
        end
    end

    // Input history used to detect a fresh start or an interval handoff.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b0;
            interval_q <= 2'b00;
        end else begin
            start_q    <= start_timer;
            interval_q <= interval;
        end
    end

    assign load = start_timer && (!start_q || (interval != interval_q));

    // Next-state and next-output logic; abort and reload take precedence
    // over counting so a coincident expiry never produces a pulse.
    always_comb begin
        state_d     = state;
        tpre_d      = tpre;
        time_left_d = time_left;
        expired_d   = 1'b0;
        if (reprogram || !start_timer) begin
            state_d     = IDLE;
            time_left_d = 4'd0;
            tpre_d      = '0;
        end else if (load) begin
            state_d     = RUN;
            time_left_d = params[interval];
            tpre_d      = '0;
        end else begin
            case (state)
                IDLE: begin
                    time_left_d = 4'd0;
                end
                RUN: begin
                    if (time_left == 4'd0) begin
                        expired_d = 1'b1;
                        state_d   = DONE;
                    end else if (tpre == TC) begin
                        tpre_d      = '0;
                        time_left_d = time_left - 4'd1;
                        if (time_left == 4'd1) begin
                            expired_d = 1'b1;
                            state_d   = DONE;
                        end
                    end else begin
                        tpre_d = tpre + PW'(1);
                    end
                end
                DONE: begin
                    time_left_d = 4'd0;
                end
                default: begin
                    state_d     = IDLE;
                    time_left_d = 4'd0;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tpre      <= '0;
            time_left <= 4'd0;
            expired   <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_d;
            tpre      <= tpre_d;
            time_left <= time_left_d;
            expired   <= expired_d;
            running   <= running_d;
        end
    end

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Directed bench for alarm_timer_ctrl with a 4-cycle second.
module tb_alarm_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_timer = 1'b0;
    logic [1:0] interval = 2'b00;
    logic       reprogram = 1'b0;
    logic [1:0] param_sel = 2'b00;
    logic [3:0] time_value = 4'd0;
    logic       expired;
    logic       one_hz_enable;
    logic [3:0] time_left;
    logic       running;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    alarm_timer_ctrl #(.CLK_FREQ_HZ(4)) dut (
        .clock(clock),
        .reset(reset),
        .start_timer(start_timer),
        .interval(interval),
        .reprogram(reprogram),
        .param_sel(param_sel),
        .time_value(time_value),
        .expired(expired),
        .one_hz_enable(one_hz_enable),
        .time_left(time_left),
        .running(running)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       st;
        logic [1:0] iv;
        logic       rp;
        logic [1:0] sel;
        logic [3:0] tv;
        logic       e_exp;
        logic [3:0] e_tl;
        logic       e_run;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock edge; outputs are sampled 1 time unit later and the
    // free-running strobe is checked against the bench's own cycle count.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        chk($sformatf("one_hz@%0d", cyc), int'(one_hz_enable), int'((cyc % 4) == 0));
    endtask

    task automatic chk_out(input string name, input int e_exp, input int e_tl, input int e_run);
        chk({name, ".expired"}, int'(expired), e_exp);
        chk({name, ".time_left"}, int'(time_left), e_tl);
        chk({name, ".running"}, int'(running), e_run);
    endtask

    initial begin
        // Short-program sequence starting from IDLE with default params.
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0}; // arm := 0
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b1}; // load 0
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b1, 4'd0, 1'b0}; // expire
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0}; // DONE
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0}; // IDLE
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 2'b01, 4'd2, 1'b0, 4'd0, 1'b0}; // driver := 2
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0, 4'd2, 1'b1}; // load 2
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0, 4'd2, 1'b1};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0, 4'd2, 1'b1};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0, 4'd2, 1'b1};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0, 4'd1, 1'b1}; // 1 s gone
        vecs[11] = '{1'b1, 2'b01, 1'b1, 2'b11, 4'd5, 1'b0, 4'd0, 1'b0}; // abort, alarm := 5
        vecs[12] = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0}; // held: no reload
        vecs[13] = '{1'b1, 2'b11, 1'b0, 2'b00, 4'd0, 1'b0, 4'd5, 1'b1}; // interval change
        vecs[14] = '{1'b0, 2'b11, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0}; // drop
        vecs[15] = '{1'b1, 2'b11, 1'b0, 2'b00, 4'd0, 1'b0, 4'd5, 1'b1}; // re-raise

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_out("reset", 0, 0, 0);
        chk("reset.one_hz", int'(one_hz_enable), 0);
        reset = 1'b0;
        cyc = 0;

        // Driver delay counts 8 seconds, expiry at load+32
        start_timer = 1'b1;
        interval = 2'b01;
        tick();
        chk_out("drv_load", 0, 8, 1);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk_out($sformatf("drv_k%0d", k), 0, 8 - k / 4, 1);
        end
        tick();
        chk_out("drv_expire", 1, 0, 0);
        tick();
        chk_out("drv_done", 0, 0, 0);
        start_timer = 1'b0;
        tick();
        chk_out("drv_idle", 0, 0, 0);

        // Drop start at time_left=2, then re-raise
        start_timer = 1'b1;
        tick();
        chk_out("drop_load", 0, 8, 1);
        for (int k = 1; k <= 24; k++) tick();
        chk_out("drop_at2", 0, 2, 1);
        start_timer = 1'b0;
        tick();
        chk_out("drop_idle", 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_out($sformatf("drop_quiet%0d", k), 0, 0, 0);
        end
        start_timer = 1'b1;
        tick();
        chk_out("drop_reload", 0, 8, 1);
        start_timer = 1'b0;
        tick();

        // Table of short sequences
        for (int i = 0; i < 16; i++) begin
            start_timer = vecs[i].st;
            interval    = vecs[i].iv;
            reprogram   = vecs[i].rp;
            param_sel   = vecs[i].sel;
            time_value  = vecs[i].tv;
            tick();
            chk_out($sformatf("vec%0d", i), int'(vecs[i].e_exp), int'(vecs[i].e_tl), int'(vecs[i].e_run));
        end
        reprogram = 1'b0;
        start_timer = 1'b0;
        tick();
        chk_out("tbl_idle", 0, 0, 0);

        // Passenger := 3, expiry exactly 12 cycles after load
        reprogram = 1'b1;
        param_sel = 2'b10;
        time_value = 4'd3;
        tick();
        reprogram = 1'b0;
        start_timer = 1'b1;
        interval = 2'b10;
        tick();
        chk_out("pas_load", 0, 3, 1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("pas_noexp%0d", k), int'(expired), 0);
        end
        tick();
        chk_out("pas_expire", 1, 0, 0);
        tick();
        chk_out("pas_single", 0, 0, 0);
        start_timer = 1'b0;
        tick();

        // Async reset mid-count restores defaults
        reprogram = 1'b1;
        param_sel = 2'b10;
        time_value = 4'd7;
        tick();
        reprogram = 1'b0;
        start_timer = 1'b1;
        interval = 2'b10;
        tick();
        for (int k = 1; k <= 8; k++) tick();
        chk_out("rst_pre", 0, 5, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_async", 0, 0, 0);
        chk("rst_async.one_hz", int'(one_hz_enable), 0);
        start_timer = 1'b0;
        interval = 2'b00;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0;
        start_timer = 1'b1;
        tick();
        chk_out("def_arm", 0, 6, 1);
        interval = 2'b01;
        tick();
        chk_out("def_drv", 0, 8, 1);
        interval = 2'b10;
        tick();
        chk_out("def_pas", 0, 15, 1);
        interval = 2'b11;
        tick();
        chk_out("def_alm", 0, 10, 1);
        start_timer = 1'b0;
        tick();

        // Interval handoff 01 -> 11 at load+10
        start_timer = 1'b1;
        interval = 2'b01;
        tick();
        for (int k = 1; k <= 10; k++) tick();
        chk_out("ho_before", 0, 6, 1);
        interval = 2'b11;
        tick();
        chk_out("ho_reload", 0, 10, 1);
        for (int j = 1; j <= 39; j++) begin
            tick();
            chk_out($sformatf("ho_j%0d", j), 0, 10 - j / 4, 1);
        end
        tick();
        chk_out("ho_expire", 1, 0, 0);
        tick();
        chk_out("ho_done", 0, 0, 0);
        start_timer = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
